// File: rtl/fft_out_serializer.sv
// ============================================================================
// Module   : fft_out_serializer
// Captures a parallel complex FFT frame and streams it one sample per cycle
// over valid/ready, in natural or bit-reversed slot order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_out_serializer #(
   parameter int DW      = 16,
   parameter int NMAX    = 32,
   parameter int BIT_REV = 0
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               frame_valid_i,
   input  logic [1:0]         fft_len_i,
   input  logic [NMAX*DW-1:0] X_R_i,
   input  logic [NMAX*DW-1:0] X_I_i,
   output logic               frame_ready_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [DW-1:0]      X_R_o,
   output logic [DW-1:0]      X_I_o,
   output logic [4:0]         index_o,
   output logic               last_o,
   output logic               overflow_o,
   output logic               len_err_o
);

   localparam int c_LOG2 = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_LOG2-1:0]   r_k;
   logic [c_LOG2-1:0]   w_k_nxt;
   logic [1:0]          r_len;
   logic [DW-1:0]       r_xr [NMAX];
   logic [DW-1:0]       r_xi [NMAX];
   logic                r_overflow;
   logic                r_len_err;

   logic [c_LOG2-1:0]   w_last_idx;
   logic [c_LOG2-1:0]   w_sel;
   logic                w_valid;
   logic                w_last;
   logic                w_hs;
   logic                w_capture;

   always_comb begin
      w_last_idx = 5'd31;
      case (r_len)
         2'b00:   w_last_idx = 5'd7;
         2'b01:   w_last_idx = 5'd15;
         default: w_last_idx = 5'd31;
      endcase
   end

   assign w_valid       = (r_state == SEND);
   assign w_last        = w_valid && (r_k == w_last_idx);
   assign w_hs          = w_valid && ready_i;
   // Ready while idle, or when the final sample leaves this cycle so the next
   // frame can follow without a bubble.
   assign frame_ready_o = (r_state == IDLE) || (w_hs && w_last);
   assign w_capture     = frame_valid_i && frame_ready_o && (fft_len_i != 2'b11);

   generate
      if (BIT_REV != 0) begin : g_bitrev
         logic [c_LOG2-1:0] w_rev;
         logic [2:0]        w_shift;
         // Reverse across all 5 bits, then drop the low zeros so the result
         // is the reversal over log2(N) bits.
         always_comb begin
            w_rev = '0;
            for (int b = 0; b < c_LOG2; b++) begin
               w_rev[b] = r_k[c_LOG2-1-b];
            end
            w_shift = 3'd0;
            case (r_len)
               2'b00:   w_shift = 3'd2;
               2'b01:   w_shift = 3'd1;
               default: w_shift = 3'd0;
            endcase
            w_sel = w_rev >> w_shift;
         end
      end else begin : g_natural
         assign w_sel = r_k;
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      case (r_state)
         IDLE: begin
            if (w_capture) begin
               w_state_nxt = SEND;
               w_k_nxt     = '0;
            end
         end
         SEND: begin
            if (w_hs) begin
               if (w_last) begin
                  w_k_nxt = '0;
                  if (!w_capture) begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_k_nxt = r_k + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_k_nxt     = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_len   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         if (w_capture) begin
            r_len <= fft_len_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NMAX; i++) begin
            r_xr[i] <= '0;
            r_xi[i] <= '0;
         end
      end else if (w_capture) begin
         for (int i = 0; i < NMAX; i++) begin
            r_xr[i] <= X_R_i[i*DW +: DW];
            r_xi[i] <= X_I_i[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_overflow <= 1'b0;
         r_len_err  <= 1'b0;
      end else begin
         r_overflow <= frame_valid_i && !frame_ready_o;
         r_len_err  <= frame_valid_i && frame_ready_o && (fft_len_i == 2'b11);
      end
   end

   assign valid_o    = w_valid;
   assign last_o     = w_last;
   assign index_o    = w_valid ? r_k : 5'd0;
   assign X_R_o      = w_valid ? r_xr[w_sel] : '0;
   assign X_I_o      = w_valid ? r_xi[w_sel] : '0;
   assign overflow_o = r_overflow;
   assign len_err_o  = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
// ============================================================================
// Module   : tb_fft_out_serializer
// Drives natural-order and bit-reversed instances with shared stimulus and
// checks both against a queue-based model of the expected sample stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_out_serializer;

   localparam int DW   = 16;
   localparam int NMAX = 32;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               frame_valid;
   logic [1:0]         fft_len;
   logic               ready;
   logic [NMAX*DW-1:0] xr_bus;
   logic [NMAX*DW-1:0] xi_bus;
   logic [DW-1:0]      fr [NMAX];
   logic [DW-1:0]      fi [NMAX];

   logic               n_frame_ready, n_valid, n_last, n_ovf, n_lerr;
   logic [DW-1:0]      n_xr, n_xi;
   logic [4:0]         n_idx;
   logic               r_frame_ready, r_valid, r_last, r_ovf, r_lerr;
   logic [DW-1:0]      r_xr, r_xi;
   logic [4:0]         r_idx;

   always #5 clk = ~clk;

   always_comb begin
      xr_bus = '0;
      xi_bus = '0;
      for (int i = 0; i < NMAX; i++) begin
         xr_bus[i*DW +: DW] = fr[i];
         xi_bus[i*DW +: DW] = fi[i];
      end
   end

   fft_out_serializer #(.DW(DW), .NMAX(NMAX), .BIT_REV(0)) u_dut_nat (
      .clk_i(clk), .rst_n_i(rst_n), .frame_valid_i(frame_valid), .fft_len_i(fft_len),
      .X_R_i(xr_bus), .X_I_i(xi_bus), .frame_ready_o(n_frame_ready), .valid_o(n_valid),
      .ready_i(ready), .X_R_o(n_xr), .X_I_o(n_xi), .index_o(n_idx), .last_o(n_last),
      .overflow_o(n_ovf), .len_err_o(n_lerr)
   );

   fft_out_serializer #(.DW(DW), .NMAX(NMAX), .BIT_REV(1)) u_dut_rev (
      .clk_i(clk), .rst_n_i(rst_n), .frame_valid_i(frame_valid), .fft_len_i(fft_len),
      .X_R_i(xr_bus), .X_I_i(xi_bus), .frame_ready_o(r_frame_ready), .valid_o(r_valid),
      .ready_i(ready), .X_R_o(r_xr), .X_I_o(r_xi), .index_o(r_idx), .last_o(r_last),
      .overflow_o(r_ovf), .len_err_o(r_lerr)
   );

   typedef struct packed {
      logic [DW-1:0] xr;
      logic [DW-1:0] xi;
      logic [4:0]    idx;
      logic          last;
   } samp_t;

   samp_t q_nat[$];
   samp_t q_rev[$];
   logic  exp_ovf;
   logic  exp_lerr;
   int    vectors     = 0;
   int    miscompares = 0;

   function automatic int bitrev(input int k, input int bits);
      int r = 0;
      for (int b = 0; b < bits; b++) begin
         if (((k >> b) & 1) != 0) r = r | (1 << (bits - 1 - b));
      end
      return r;
   endfunction

   function automatic logic model_ready();
      return (q_nat.size() == 0) || (ready && q_nat.size() == 1);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int n, input int bits);
      samp_t s;
      int    j;
      for (int k = 0; k < n; k++) begin
         s.idx  = 5'(k);
         s.last = (k == n - 1);
         s.xr   = fr[k];
         s.xi   = fi[k];
         q_nat.push_back(s);
         j      = bitrev(k, bits);
         s.xr   = fr[j];
         s.xi   = fi[j];
         q_rev.push_back(s);
      end
   endtask

   task automatic check_outputs();
      logic busy;
      busy = (q_nat.size() > 0);
      cmp("frame_ready_nat", n_frame_ready, model_ready());
      cmp("frame_ready_rev", r_frame_ready, model_ready());
      cmp("valid_nat", n_valid, busy);
      cmp("valid_rev", r_valid, busy);
      cmp("overflow_nat", n_ovf, exp_ovf);
      cmp("overflow_rev", r_ovf, exp_ovf);
      cmp("len_err_nat", n_lerr, exp_lerr);
      cmp("len_err_rev", r_lerr, exp_lerr);
      if (busy) begin
         cmp("xr_nat", n_xr, q_nat[0].xr);
         cmp("xi_nat", n_xi, q_nat[0].xi);
         cmp("index_nat", n_idx, q_nat[0].idx);
         cmp("last_nat", n_last, q_nat[0].last);
         cmp("xr_rev", r_xr, q_rev[0].xr);
         cmp("xi_rev", r_xi, q_rev[0].xi);
         cmp("index_rev", r_idx, q_rev[0].idx);
         cmp("last_rev", r_last, q_rev[0].last);
      end
   endtask

   task automatic drive_check(input logic fv, input logic [1:0] len, input logic rdy);
      @(negedge clk);
      frame_valid = fv;
      fft_len     = len;
      ready       = rdy;
      #1;
      check_outputs();
   endtask

   task automatic clk_update();
      logic rm;
      @(posedge clk);
      if (!rst_n) begin
         q_nat.delete();
         q_rev.delete();
         exp_ovf  = 1'b0;
         exp_lerr = 1'b0;
      end else begin
         rm       = model_ready();
         exp_ovf  = frame_valid && !rm;
         exp_lerr = frame_valid && rm && (fft_len == 2'b11);
         if (q_nat.size() > 0 && ready) begin
            void'(q_nat.pop_front());
            void'(q_rev.pop_front());
         end
         if (frame_valid && rm && fft_len != 2'b11) begin
            push_frame(8 << fft_len, 3 + int'(fft_len));
         end
      end
      #1;
   endtask

   task automatic step(input logic fv, input logic [1:0] len, input logic rdy);
      drive_check(fv, len, rdy);
      clk_update();
   endtask

   task automatic rand_data();
      for (int i = 0; i < NMAX; i++) begin
         fr[i] = DW'($urandom);
         fi[i] = DW'($urandom);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (q_nat.size() > 0 && guard < 400) begin
         step(1'b0, 2'b00, 1'b1);
         guard++;
      end
      cmp("drain_done", q_nat.size(), 0);
   endtask

   task automatic advance_to(input int idx);
      int guard = 0;
      while (q_nat.size() > 0 && q_nat[0].idx != 5'(idx) && guard < 64) begin
         step(1'b0, 2'b00, 1'b1);
         guard++;
      end
      cmp("advance_reached", (q_nat.size() > 0) ? int'(q_nat[0].idx) : -1, idx);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n       = 1'b0;
      frame_valid = 1'b0;
      #1;
      q_nat.delete();
      q_rev.delete();
      exp_ovf  = 1'b0;
      exp_lerr = 1'b0;
      cmp("valid_on_reset_nat", n_valid, 1'b0);
      cmp("valid_on_reset_rev", r_valid, 1'b0);
      clk_update();
      step(1'b0, 2'b00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cmp("ready_after_reset", n_frame_ready, 1'b1);
   endtask

   initial begin
      int rev8 [8];
      int hs;
      int guard;
      logic t;
      int r;
      logic fv;
      logic [1:0] len;

      rev8 = '{0, 4, 2, 6, 1, 5, 3, 7};
      rst_n = 1'b0; frame_valid = 1'b0; fft_len = 2'b00; ready = 1'b0;
      exp_ovf = 1'b0; exp_lerr = 1'b0;
      for (int i = 0; i < NMAX; i++) begin
         fr[i] = '0;
         fi[i] = '0;
      end

      // Reset state
      drive_check(1'b0, 2'b00, 1'b0);
      cmp("reset_xr", n_xr, 16'h0000);
      cmp("reset_index", n_idx, 5'd0);
      cmp("reset_last", n_last, 1'b0);
      clk_update();
      step(1'b0, 2'b00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      clk_update();

      // N = 8, natural and bit-reversed, pinned by literal sequences
      for (int k = 0; k < NMAX; k++) begin
         fr[k] = DW'(k);
         fi[k] = DW'(100 + k);
      end
      step(1'b1, 2'b00, 1'b1);
      for (int j = 0; j < 8; j++) begin
         drive_check(1'b0, 2'b00, 1'b1);
         cmp("n8_lit_xr_nat", n_xr, 32'(j));
         cmp("n8_lit_xi_nat", n_xi, 32'(100 + j));
         cmp("n8_lit_xr_rev", r_xr, 32'(rev8[j]));
         cmp("n8_lit_last", n_last, (j == 7));
         clk_update();
      end
      drive_check(1'b0, 2'b00, 1'b1);
      cmp("n8_idle_after", n_valid, 1'b0);
      clk_update();

      // N = 32 with ready toggling
      rand_data();
      step(1'b1, 2'b10, 1'b1);
      hs = 0; guard = 0; t = 1'b1;
      while (q_nat.size() > 0 && guard < 200) begin
         drive_check(1'b0, 2'b10, t);
         if (t && n_valid) hs++;
         clk_update();
         t = ~t;
         guard++;
      end
      cmp("n32_drained", q_nat.size(), 0);
      cmp("n32_handshakes", hs, 32);

      // Back-to-back: N = 8 then N = 16 with no bubble
      rand_data();
      step(1'b1, 2'b00, 1'b1);
      guard = 0;
      while (q_nat.size() > 1 && guard < 20) begin
         step(1'b0, 2'b00, 1'b1);
         guard++;
      end
      for (int k = 0; k < NMAX; k++) fr[k] = DW'(16'h8000 + k);
      drive_check(1'b1, 2'b01, 1'b1);
      cmp("b2b_frame_ready", n_frame_ready, 1'b1);
      cmp("b2b_last", n_last, 1'b1);
      clk_update();
      drive_check(1'b0, 2'b00, 1'b1);
      cmp("b2b_valid", n_valid, 1'b1);
      cmp("b2b_xr", n_xr, 16'h8000);
      cmp("b2b_index", n_idx, 5'd0);
      clk_update();
      drain();

      // Overflow at index 3, then reserved length in IDLE
      rand_data();
      step(1'b1, 2'b01, 1'b1);
      advance_to(3);
      step(1'b1, 2'b00, 1'b1);
      drive_check(1'b0, 2'b00, 1'b1);
      cmp("ovf_pulse", n_ovf, 1'b1);
      cmp("ovf_index", n_idx, 5'd4);
      clk_update();
      drive_check(1'b0, 2'b00, 1'b1);
      cmp("ovf_one_cycle", n_ovf, 1'b0);
      clk_update();
      drain();
      step(1'b1, 2'b11, 1'b1);
      drive_check(1'b0, 2'b00, 1'b1);
      cmp("len_err_pulse", n_lerr, 1'b1);
      cmp("len_err_no_valid", n_valid, 1'b0);
      clk_update();

      // Reset at index 5 of a 16-point frame
      rand_data();
      step(1'b1, 2'b01, 1'b1);
      advance_to(5);
      do_reset();
      clk_update();
      rand_data();
      step(1'b1, 2'b01, 1'b1);
      drive_check(1'b0, 2'b00, 1'b1);
      cmp("post_reset_index", n_idx, 5'd0);
      cmp("post_reset_valid", n_valid, 1'b1);
      clk_update();
      drain();

      // Randomized traffic
      repeat (3000) begin
         fv  = ($urandom_range(0, 4) == 0);
         r   = $urandom_range(0, 9);
         len = (r == 0) ? 2'b11 : 2'(r % 3);
         if (fv) rand_data();
         step(fv, len, ($urandom_range(0, 9) < 7));
      end
      drain();
      step(1'b0, 2'b00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
